// File: rtl/stack_prog_loader_pkg.sv
// rtl/stack_prog_loader_pkg.sv - shared types and constants for the stack CPU program loader
package stack_prog_loader_pkg;

    localparam int OPC_W  = 3;
    localparam int FLAG_W = 1;
    localparam int VAL_W  = 10;

    typedef enum logic [OPC_W-1:0] {
        PUSH_OP = 3'd0,
        ADD_OP  = 3'd1,
        SUB_OP  = 3'd2,
        DUP_OP  = 3'd3,
        JMP_OP  = 3'd4,
        JZ_OP   = 3'd5,
        POP_OP  = 3'd6,
        HALT_OP = 3'd7
    } opcode_t;

    localparam logic [2:0] ST_LOAD    = 3'd0;
    localparam logic [2:0] ST_FULL    = 3'd1;
    localparam logic [2:0] ST_RELEASE = 3'd2;
    localparam logic [2:0] ST_RUN     = 3'd3;
    localparam logic [2:0] ST_HALTED  = 3'd4;

    typedef enum logic [2:0] {
        LOAD    = ST_LOAD,
        FULL    = ST_FULL,
        RELEASE = ST_RELEASE,
        RUN     = ST_RUN,
        HALTED  = ST_HALTED
    } loader_state_t;

endpackage

// File: rtl/prog_ram.sv
// rtl/prog_ram.sv - program store: one synchronous write port, asynchronous read
module prog_ram #(
    parameter int WIDTH   = 14,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/stack_prog_loader.sv
// rtl/stack_prog_loader.sv - streams a program into memory, holds the CPU in reset, then serves mem[pc]
module stack_prog_loader #(
    parameter int INSTR_WIDTH = 14,
    parameter int PC_WIDTH    = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [INSTR_WIDTH-1:0] load_data,
    input  logic                   load_last,
    input  logic                   start,
    input  logic [PC_WIDTH-1:0]    pc,
    input  logic                   cpu_halt,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   cpu_reset,
    output logic [PC_WIDTH:0]      prog_len,
    output logic                   running,
    output logic                   overflow
);

    import stack_prog_loader_pkg::*;

    localparam logic [INSTR_WIDTH-1:0] HALT_INSTR = {HALT_OP, {(INSTR_WIDTH-OPC_W){1'b0}}};
    localparam logic [PC_WIDTH-1:0]    LAST_ADDR  = {PC_WIDTH{1'b1}};

    loader_state_t              state_q, state_d;
    logic [PC_WIDTH-1:0]        wr_addr_q, wr_addr_d;
    logic [PC_WIDTH:0]          prog_len_q, prog_len_d;
    logic                       overflow_q, overflow_d;
    logic                       cpu_reset_q, cpu_reset_d;
    logic                       running_q, running_d;
    logic                       accept;
    logic                       we;
    logic [INSTR_WIDTH-1:0]     rd_data;

    prog_ram #(
        .WIDTH  (INSTR_WIDTH),
        .ADDR_W (PC_WIDTH)
    ) u_prog_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_addr_q),
        .wdata (load_data),
        .raddr (pc),
        .rdata (rd_data)
    );

    assign load_ready = (state_q == LOAD) || (state_q == FULL);
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        prog_len_d = prog_len_q;
        overflow_d = overflow_q;
        we         = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (accept) begin
                    we         = 1'b1;
                    wr_addr_d  = wr_addr_q + 1'b1;
                    prog_len_d = prog_len_q + 1'b1;
                    if (load_last) begin
                        state_d = RELEASE;
                    end else if (wr_addr_q == LAST_ADDR) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                // memory is full: beats are consumed so the source drains, but never stored
                if (accept) begin
                    overflow_d = 1'b1;
                    if (load_last) begin
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: state_d = RUN;
            RUN: begin
                if (cpu_halt) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (load_valid) begin
                    state_d    = LOAD;
                    wr_addr_d  = '0;
                    prog_len_d = '0;
                    overflow_d = 1'b0;
                end else if (start) begin
                    state_d = RELEASE;
                end
            end
            default: state_d = LOAD;
        endcase
        cpu_reset_d = (state_d == LOAD) || (state_d == FULL) || (state_d == RELEASE);
        running_d   = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= LOAD;
            wr_addr_q   <= '0;
            prog_len_q  <= '0;
            overflow_q  <= 1'b0;
            cpu_reset_q <= 1'b1;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            prog_len_q  <= prog_len_d;
            overflow_q  <= overflow_d;
            cpu_reset_q <= cpu_reset_d;
            running_q   <= running_d;
        end
    end

    always_comb begin
        instruction = HALT_INSTR;
        if (((state_q == RUN) || (state_q == HALTED)) && ({1'b0, pc} < prog_len_q)) begin
            instruction = rd_data;
        end
    end

    assign cpu_reset = cpu_reset_q;
    assign running   = running_q;
    assign prog_len  = prog_len_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_stack_prog_loader.sv
// tb/tb_stack_prog_loader.sv - randomized scoreboard bench for stack_prog_loader
module tb_stack_prog_loader;

    import stack_prog_loader_pkg::*;

    localparam int IW    = 14;
    localparam int PW    = 5;
    localparam int DEPTH = 2**PW;
    localparam logic [IW-1:0] HALT_W = {HALT_OP, {(IW-OPC_W){1'b0}}};

    logic          clk;
    logic          reset;
    logic          load_valid;
    logic          load_ready;
    logic [IW-1:0] load_data;
    logic          load_last;
    logic          start;
    logic [PW-1:0] pc;
    logic          cpu_halt;
    logic [IW-1:0] instruction;
    logic          cpu_reset;
    logic [PW:0]   prog_len;
    logic          running;
    logic          overflow;

    stack_prog_loader #(.INSTR_WIDTH(IW), .PC_WIDTH(PW)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_last   (load_last),
        .start       (start),
        .pc          (pc),
        .cpu_halt    (cpu_halt),
        .instruction (instruction),
        .cpu_reset   (cpu_reset),
        .prog_len    (prog_len),
        .running     (running),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        int            cyc;
        int            tag;
        logic [IW-1:0] instr;
        bit            crst;
        bit            run;
        bit            rdy;
        int            plen;
        bit            ovf;
    } exp_t;

    exp_t          exp_q[$];
    logic [IW-1:0] prog[$];
    logic [IW-1:0] pend[$];
    bit            movf;
    int            n_cmp = 0;
    int            n_bad = 0;

    function automatic logic [IW-1:0] exp_instr(input int p);
        if (p < prog.size()) return prog[p];
        return HALT_W;
    endfunction

    task automatic push_exp(input int tag, input logic [IW-1:0] instr, input bit crst, input bit run, input bit rdy);
        exp_t e;
        e.cyc   = cycle;
        e.tag   = tag;
        e.instr = instr;
        e.crst  = crst;
        e.run   = run;
        e.rdy   = rdy;
        e.plen  = prog.size();
        e.ovf   = movf;
        exp_q.push_back(e);
    endtask

    task automatic cmp(input int tag, input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s tag=%0d cyc=%0d got=%0h want=%0h", nm, tag, cycle, act, want);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cycle) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.cyc < cycle) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stale_entry tag=%0d got=cyc%0d want=cyc%0d", e.tag, cycle, e.cyc);
            end else begin
                cmp(e.tag, "instruction", 32'(instruction), 32'(e.instr));
                cmp(e.tag, "cpu_reset",   32'(cpu_reset),   32'(e.crst));
                cmp(e.tag, "running",     32'(running),     32'(e.run));
                cmp(e.tag, "load_ready",  32'(load_ready),  32'(e.rdy));
                cmp(e.tag, "prog_len",    32'(prog_len),    32'(e.plen));
                cmp(e.tag, "overflow",    32'(overflow),    32'(e.ovf));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_pc();
        if (prog.size() > 0 && $urandom_range(0, 1) == 1) pc = PW'($urandom_range(0, prog.size() - 1));
        else pc = PW'($urandom_range(0, DEPTH - 1));
    endtask

    task automatic noise();
        start    = ($urandom_range(0, 3) == 0);
        cpu_halt = ($urandom_range(0, 3) == 0);
        rand_pc();
    endtask

    task automatic fill(input int n);
        pend.delete();
        for (int i = 0; i < n; i++) pend.push_back(IW'($urandom));
    endtask

    // Streams pend[] with random idle gaps; returns with the DUT in RUN.
    task automatic load_prog();
        int n;
        n = pend.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                int g;
                g = $urandom_range(0, 2);
                for (int j = 0; j < g; j++) begin
                    load_valid = 1'b0;
                    load_data  = IW'($urandom);
                    load_last  = 1'($urandom);
                    noise();
                    push_exp(1, HALT_W, 1'b1, 1'b0, 1'b1);
                    step();
                end
            end
            load_valid = 1'b1;
            load_data  = pend[i];
            load_last  = (i == n - 1);
            noise();
            push_exp(2, HALT_W, 1'b1, 1'b0, 1'b1);
            step();
            if (prog.size() < DEPTH) prog.push_back(pend[i]);
            else movf = 1'b1;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        noise();
        push_exp(3, HALT_W, 1'b1, 1'b0, 1'b0);
        step();
    endtask

    task automatic run_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            start    = ($urandom_range(0, 3) == 0);
            cpu_halt = 1'b0;
            rand_pc();
            push_exp(4, exp_instr(int'(pc)), 1'b0, 1'b1, 1'b0);
            step();
        end
    endtask

    task automatic run_pc(input int p);
        start    = 1'b0;
        cpu_halt = 1'b0;
        pc       = PW'(p);
        push_exp(12, exp_instr(p), 1'b0, 1'b1, 1'b0);
        step();
    endtask

    task automatic halt_cpu();
        cpu_halt = 1'b1;
        start    = 1'b0;
        rand_pc();
        push_exp(5, exp_instr(int'(pc)), 1'b0, 1'b1, 1'b0);
        step();
        for (int i = 0; i < 2; i++) begin
            cpu_halt = 1'($urandom);
            start    = 1'b0;
            rand_pc();
            push_exp(6, exp_instr(int'(pc)), 1'b0, 1'b0, 1'b0);
            step();
        end
        cpu_halt = 1'b0;
    endtask

    task automatic restart();
        start = 1'b1;
        rand_pc();
        push_exp(7, exp_instr(int'(pc)), 1'b0, 1'b0, 1'b0);
        step();
        start = 1'b0;
        rand_pc();
        push_exp(8, HALT_W, 1'b1, 1'b0, 1'b0);
        step();
    endtask

    task automatic begin_new(input bit st);
        load_valid = 1'b1;
        load_data  = IW'($urandom);
        load_last  = 1'b0;
        start      = st;
        rand_pc();
        push_exp(9, exp_instr(int'(pc)), 1'b0, 1'b0, 1'b0);
        step();
        start = 1'b0;
        prog.delete();
        movf = 1'b0;
    endtask

    task automatic reset_in_run();
        reset = 1'b0;
        rand_pc();
        push_exp(10, exp_instr(int'(pc)), 1'b0, 1'b1, 1'b0);
        step();
        reset      = 1'b1;
        load_valid = 1'b0;
        prog.delete();
        movf = 1'b0;
        push_exp(11, HALT_W, 1'b1, 1'b0, 1'b1);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        start = 1'b0; pc = '0; cpu_halt = 1'b0; movf = 1'b0;
        step();
        step();
        reset = 1'b1;
        push_exp(0, HALT_W, 1'b1, 1'b0, 1'b1);
        step();

        pend = '{14'h1005, 14'h1003, 14'h2000};
        load_prog();
        for (int p = 0; p < 4; p++) run_pc(p);
        run_cycles(3);
        halt_cpu();
        restart();
        run_cycles(4);
        halt_cpu();

        begin_new(1'b1);
        fill(35);
        load_prog();
        run_cycles(8);
        halt_cpu();

        begin_new(1'b0);
        fill(DEPTH);
        load_prog();
        run_cycles(6);
        halt_cpu();

        begin_new(1'b1);
        fill(1);
        load_prog();
        run_cycles(3);
        reset_in_run();

        for (int it = 0; it < 12; it++) begin
            fill($urandom_range(1, 40));
            load_prog();
            run_cycles($urandom_range(2, 8));
            case ($urandom_range(0, 2))
                0: begin
                    halt_cpu();
                    restart();
                    run_cycles(3);
                    halt_cpu();
                    begin_new(1'($urandom));
                end
                1: begin
                    halt_cpu();
                    begin_new(1'($urandom));
                end
                default: reset_in_run();
            endcase
        end

        load_valid = 1'b0;
        step();
        step();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
